// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator with one-hot gt/eq/lt result and done pulse.
// Optional macro SERIAL_COMPARATOR_EARLY_EXIT_EN: MSB-first streams finish on the first differing pair.
module serial_comparator #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic x,
  input  logic y,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_GT = 2'd1,
    REL_LT = 2'd2
  } rel_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  rel_t             rel, rel_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic [2:0]       res_r, res_n;
  rel_t             rel_upd;
  logic             decided;

  // MSB-first locks on the first difference; LSB-first lets each later difference override.
  function automatic rel_t rel_step(input rel_t cur, input logic xb, input logic yb);
    rel_t r;
    r = cur;
    if ((xb != yb) && (!MSB_FIRST || (cur == REL_EQ)))
      r = xb ? REL_GT : REL_LT;
    return r;
  endfunction

  function automatic logic [2:0] rel_onehot(input rel_t r);
    logic [2:0] oh;
    case (r)
      REL_GT:  oh = 3'b100;
      REL_LT:  oh = 3'b001;
      default: oh = 3'b010;
    endcase
    return oh;
  endfunction

  assign rel_upd = rel_step(rel, x, y);

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  assign decided = MSB_FIRST && (rel_upd != REL_EQ);
`else
  assign decided = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rel_n   = rel;
    busy_n  = busy_r;
    done_n  = 1'b0;
    res_n   = res_r;
    case (state)
      S_IDLE, S_DONE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = S_RUN;
          cnt_n   = '0;
          rel_n   = REL_EQ;
          busy_n  = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          cnt_n = cnt + 1'b1;
          rel_n = rel_upd;
          if ((cnt == LAST_IDX) || decided) begin
            state_n = S_DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            res_n   = rel_onehot(rel_upd);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rel    <= REL_EQ;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= 3'b000;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rel    <= rel_n;
      busy_r <= busy_n;
      done_r <= done_n;
      res_r  <= res_n;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign gt   = res_r[2];
  assign eq   = res_r[1];
  assign lt   = res_r[0];

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator: three instances (W4 MSB-first, W4 LSB-first, W1).
module tb_serial_comparator;

`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_s, bv_s, x_s, y_s;
  logic [2:0] busy_s, done_s, gt_s, eq_s, lt_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] idx;
    logic [2:0] res;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
    .clk(clk), .rst(rst), .start(start_s[0]), .bit_valid(bv_s[0]), .x(x_s[0]), .y(y_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .gt(gt_s[0]), .eq(eq_s[0]), .lt(lt_s[0]));

  serial_comparator #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
    .clk(clk), .rst(rst), .start(start_s[1]), .bit_valid(bv_s[1]), .x(x_s[1]), .y(y_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .gt(gt_s[1]), .eq(eq_s[1]), .lt(lt_s[1]));

  serial_comparator #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .start(start_s[2]), .bit_valid(bv_s[2]), .x(x_s[2]), .y(y_s[2]),
    .busy(busy_s[2]), .done(done_s[2]), .gt(gt_s[2]), .eq(eq_s[2]), .lt(lt_s[2]));

  function automatic logic [2:0] res_of(input int i);
    return {gt_s[i], eq_s[i], lt_s[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_s[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("unexpected_done_u%0d", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check($sformatf("done_unit_u%0d", i), 32'(i), 32'(e.idx));
          check($sformatf("result_u%0d", i), 32'(res_of(i)), 32'(e.res));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one comparison; returns just after the edge consuming the last pair.
  task automatic compare(input int i, input int w, input bit msb,
                         input logic [7:0] xv, input logic [7:0] yv,
                         input logic [2:0] res, input logic [2:0] prev,
                         input int done_after, input int stall_at,
                         input int stall_len, input int start_at);
    exp_t e;
    int   b;
    e.idx = 2'(i);
    e.res = res;
    sb_q.push_back(e);
    start_s[i] = 1'b1;
    tick();
    start_s[i] = 1'b0;
    check($sformatf("start_busy_u%0d", i), 32'(busy_s[i]), 32'd1);
    check($sformatf("start_done_u%0d", i), 32'(done_s[i]), 32'd0);
    check($sformatf("start_hold_u%0d", i), 32'(res_of(i)), 32'(prev));
    for (int k = 0; k < w; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bv_s[i] = 1'b0;
          x_s[i]  = 1'b1;
          y_s[i]  = 1'b0;
          tick();
          check($sformatf("stall_busy_u%0d", i), 32'(busy_s[i]), 32'd1);
          check($sformatf("stall_done_u%0d", i), 32'(done_s[i]), 32'd0);
        end
      end
      b          = msb ? (w - 1 - k) : k;
      bv_s[i]    = 1'b1;
      x_s[i]     = xv[b];
      y_s[i]     = yv[b];
      start_s[i] = (k == start_at);
      tick();
      start_s[i] = 1'b0;
      check($sformatf("done_u%0d_p%0d", i, k + 1), 32'(done_s[i]), 32'(k + 1 == done_after));
      check($sformatf("busy_u%0d_p%0d", i, k + 1), 32'(busy_s[i]), 32'(k + 1 < done_after));
      check($sformatf("res_u%0d_p%0d", i, k + 1), 32'(res_of(i)),
            32'((k + 1 < done_after) ? prev : res));
    end
    bv_s[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start_s = '0; bv_s = '0; x_s = '0; y_s = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy_u%0d", i), 32'(busy_s[i]), 32'd0);
      check($sformatf("rst_done_u%0d", i), 32'(done_s[i]), 32'd0);
      check($sformatf("rst_res_u%0d", i), 32'(res_of(i)), 32'd0);
    end
    tick();

    // X=1011 vs Y=1001 MSB-first: first difference on the 3rd pair
    compare(0, 4, 1'b1, 8'b1011, 8'b1001, 3'b100, 3'b000, EE ? 3 : 4, -1, 0, -1);
    tick();
    // 0101 vs 0110 with a start pulse mid-run that must be ignored
    compare(0, 4, 1'b1, 8'b0101, 8'b0110, 3'b001, 3'b100, EE ? 3 : 4, -1, 0, 1);
    tick();
    // Equal words, then a second comparison started in the DONE cycle
    compare(0, 4, 1'b1, 8'b0110, 8'b0110, 3'b010, 3'b001, 4, -1, 0, -1);
    compare(0, 4, 1'b1, 8'b0001, 8'b0000, 3'b100, 3'b010, 4, -1, 0, -1);
    tick();

    // Reset mid-run after 2 pairs, with start and bit_valid also high
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bv_s[0] = 1'b1; x_s[0] = 1'b1; y_s[0] = (k == 0);
      tick();
    end
    check("pre_rst_busy", 32'(busy_s[0]), 32'd1);
    rst = 1'b1; start_s[0] = 1'b1; bv_s[0] = 1'b1;
    tick();
    check("midrun_rst_busy", 32'(busy_s[0]), 32'd0);
    check("midrun_rst_done", 32'(done_s[0]), 32'd0);
    check("midrun_rst_res", 32'(res_of(0)), 32'd0);
    rst = 1'b0; start_s[0] = 1'b0; bv_s[0] = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy_s[0]), 32'd0);
    check("post_rst_done", 32'(done_s[0]), 32'd0);
    compare(0, 4, 1'b1, 8'b1001, 8'b1001, 3'b010, 3'b000, 4, -1, 0, -1);
    tick();

    // LSB-first: X=0110 Y=1010, 2-cycle stall after pair 2, last difference says lt
    compare(1, 4, 1'b0, 8'b0110, 8'b1010, 3'b001, 3'b000, 4, 2, 2, -1);
    tick();
    // LSB-first: X=1000 Y=0111, early lt differences overridden by top bit
    compare(1, 4, 1'b0, 8'b1000, 8'b0111, 3'b100, 3'b001, 4, -1, 0, -1);
    tick();

    // WIDTH=1
    compare(2, 1, 1'b1, 8'b0, 8'b1, 3'b001, 3'b000, 1, -1, 0, -1);
    tick();
    compare(2, 1, 1'b1, 8'b1, 8'b1, 3'b010, 3'b001, 1, -1, 0, -1);

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Parametrised sequential successor to the two-input comparator primitive.
- Compares two WIDTH-bit unsigned words presented bit-serially on x and y, one bit pair per accepted cycle.
- Produces a registered one-hot gt/eq/lt result with a single-cycle done pulse.
- Sits between serial input shifters and downstream control logic; supports MSB-first and LSB-first streams.

Parameters:
- WIDTH, 8: number of bit pairs per comparison; legal range 1..255.
- MSB_FIRST, 1: 1 = stream order MSB first; 0 = stream order LSB first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a new comparison; accepted only in IDLE or DONE.
- bit_valid  input  1  current x/y bit pair is valid; sampled only in RUN.
- x  input  1  serial bit of operand X.
- y  input  1  serial bit of operand Y.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- gt  output  1  X > Y; held until the next start.
- eq  output  1  X == Y; held until the next start.
- lt  output  1  X < Y; held until the next start.

Behaviour:
- Reset: the edge with rst=1 forces state=IDLE and sets busy, done, gt, eq and lt to 0. The bit counter and internal relation register are also cleared. rst overrides all other inputs, including mid-RUN; a partial comparison is discarded with no done pulse.
- Bit counter width is $clog2(WIDTH+1). Internal relation register rel encodes EQ, GT or LT.
- IDLE to RUN: on an edge with start=1, counter is set to 0, rel is set to EQ and busy is set to 1. gt/eq/lt keep their previous values until done.
- RUN, bit_valid=0: stall. Nothing changes.
- RUN, bit_valid=1: the x/y pair is consumed and the counter increments.
  - MSB_FIRST=1: rel updates only while rel==EQ. On x!=y, rel becomes GT if x=1, else LT. Later bits are ignored.
  - MSB_FIRST=0: every pair with x!=y overwrites rel (GT if x=1, else LT). Pairs with x==y leave rel unchanged, so the last differing bit (most significant) wins.
- RUN to DONE: on the edge that consumes the WIDTH-th pair:
  - state becomes DONE, busy becomes 0 and done becomes 1.
  - gt/eq/lt load the final rel. The pair consumed on that edge is included.
  - Exactly one of gt/eq/lt is 1.
- DONE: lasts exactly one cycle. Without start, next edge goes to IDLE with done=0. With start=1, next edge goes directly to RUN with done=0 (back-to-back comparisons).
- start while in RUN: ignored.
- bit_valid while in IDLE or DONE: ignored.
- Latency with continuous bit_valid: done is high in the cycle after WIDTH consuming edges, i.e. WIDTH+1 cycles after the start edge.
- WIDTH=1: one consuming edge goes straight to DONE.

Optional Feature:
- Macro: SERIAL_COMPARATOR_EARLY_EXIT_EN.
- Defined and MSB_FIRST=1: the first consuming edge with x!=y transitions to DONE immediately. done pulses and gt/lt load the decided value; remaining bit pairs are not consumed. Equal words still take WIDTH pairs.
- Defined and MSB_FIRST=0: no effect.
- Undefined: every comparison always consumes exactly WIDTH pairs.

Test Plan:
- WIDTH=4, MSB_FIRST=1, macro undefined. X=1011, Y=1001 streamed with bit_valid held 1 -> done pulses once in the cycle after the 4th pair; gt=1, eq=0, lt=0; busy high for exactly 4 cycles.
- Same stimulus with SERIAL_COMPARATOR_EARLY_EXIT_EN defined -> done after the 3rd pair (first difference at bit 1); gt=1; the 4th pair is ignored and stays in IDLE.
- WIDTH=4, MSB_FIRST=0. X=0110, Y=1010 sent LSB first (pairs 0/0, 1/1, 1/0, 0/1), with bit_valid deasserted for 2 cycles after pair 2 -> no progress during the stall; done after pair 4 with lt=1 (last differing bit decides).
- WIDTH=4, both operands 0110, followed by start asserted in the DONE cycle -> eq=1 and done high for 1 cycle. Second comparison begins immediately with no IDLE cycle; eq stays 1 until the second done.
- Assert rst after 2 pairs of a comparison -> busy=0, done=0, gt=eq=lt=0 on the next edge and no done pulse. A fresh comparison then completes normally.
- WIDTH=1: pair 0/1 -> done after the first consuming edge with lt=1. A start pulse during RUN in a WIDTH=4 run does not restart the counter.
